button_debounce: RTL and testbench

//  Conditions one raw launchpad pad/button into a clean, debounced level that drives
//  the button_inp input of the LED event blocks (event_NN wave chains).
//  - 2-FF synchroniser, debounce FSM, one-cycle press/release strobes.
//  - Saturating hold counter with a long-press flag.
//  - Sits between the board pin and every event_* block.

---
 rtl/button_debounce.sv | 184 ++++++++++++++++++
 tb/tb_button_debounce.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Conditions one raw launchpad pad/button into a clean debounced
//               level for the event_* wave chains (button_inp). A two-flop
//               synchroniser feeds a debounce FSM, which produces one-cycle
//               press/release strobes, a saturating hold counter and a
//               long-press flag.
//
// Optional feature (compile-time macro):
//   HOLD_STRETCH_EN : after an accepted release, keep btn_level high for
//                     MIN_HOLD more cycles (STRETCH state). If the macro is
//                     undefined, the release goes straight to IDLE.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rst          in   1       synchronous active-high reset
//   btn_raw      in   1       asynchronous raw pad input
//   btn_level    out  1       debounced pressed level
//   btn_press    out  1       one-cycle strobe after btn_level 0->1
//   btn_release  out  1       one-cycle strobe after btn_level 1->0
//   long_press   out  1       pressed and hold_cnt >= LONG_CYCLES
//   hold_cnt     out  HOLD_W  cycles spent pressed, saturating
//
// Revision    : 1.0  initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    parameter int ACTIVE_LOW      = 0,
    parameter int MIN_HOLD        = 6,
    parameter int HOLD_W          = 16,
    parameter int LONG_CYCLES     = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    output logic              btn_level,
    output logic              btn_press,
    output logic              btn_release,
    output logic              long_press,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [2:0] c_st_idle         = 3'd0;
    localparam logic [2:0] c_st_press_wait   = 3'd1;
    localparam logic [2:0] c_st_pressed      = 3'd2;
    localparam logic [2:0] c_st_release_wait = 3'd3;
`ifdef HOLD_STRETCH_EN
    localparam logic [2:0] c_st_stretch      = 3'd4;
    localparam logic [CNT_W-1:0] c_min_hold  = CNT_W'(MIN_HOLD);
`endif

    localparam logic              c_invert   = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  c_deb      = CNT_W'(DEBOUNCE_CYCLES);
    // Largest value the debounce/stretch counter ever needs to reach; the
    // counter parks there instead of wrapping.
    localparam logic [CNT_W-1:0]  c_cnt_top  =
        CNT_W'((DEBOUNCE_CYCLES > MIN_HOLD) ? DEBOUNCE_CYCLES : MIN_HOLD);
    localparam logic [HOLD_W-1:0] c_long     = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] c_hold_max = '1;

    logic              r_sync1;
    logic              r_sync2;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic [HOLD_W-1:0] r_hold;

    logic              w_pin;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [HOLD_W-1:0] w_hold_inc;

    // Normalise polarity before the synchroniser so "1" always means pressed.
    assign w_pin      = btn_raw ^ c_invert;
    assign w_cnt_inc  = (r_cnt == c_cnt_top) ? r_cnt : r_cnt + 1'b1;
    assign w_hold_inc = (r_hold == c_hold_max) ? r_hold : r_hold + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= '0;
        end else begin
            r_sync1   <= w_pin;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (r_sync2) begin
                        r_state <= c_st_press_wait;
                        r_cnt   <= CNT_W'(1);
                    end
                end

                c_st_press_wait: begin
                    if (!r_sync2) begin
                        r_state <= c_st_idle;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_deb) begin
                        r_state <= c_st_pressed;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                        r_hold  <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_st_pressed: begin
                    r_hold <= w_hold_inc;
                    if (!r_sync2) begin
                        r_state <= c_st_release_wait;
                        r_cnt   <= CNT_W'(1);
                    end
                end

                c_st_release_wait: begin
                    if (r_sync2) begin
                        r_state <= c_st_pressed;
                        r_cnt   <= '0;
                        r_hold  <= w_hold_inc;
                    end else if (r_cnt == c_deb) begin
`ifdef HOLD_STRETCH_EN
                        // Level stays high; hold count is frozen while stretching.
                        r_state <= c_st_stretch;
                        r_cnt   <= CNT_W'(1);
`else
                        r_state   <= c_st_idle;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_hold    <= '0;
`endif
                    end else begin
                        r_cnt  <= w_cnt_inc;
                        r_hold <= w_hold_inc;
                    end
                end

`ifdef HOLD_STRETCH_EN
                c_st_stretch: begin
                    // The pin is deliberately ignored here so every downstream
                    // wave sees the full stretch.
                    if (r_cnt == c_min_hold) begin
                        r_state   <= c_st_idle;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_hold    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
`endif

                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign hold_cnt    = r_hold;
    assign long_press  = r_level & (r_hold >= c_long);

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Self-checking bench for button_debounce. A per-cycle vector
//               table covers reset, glitch rejection, press, release-glitch
//               and release; hand sequences cover hold/long-press, stretch,
//               reset mid-operation, active-low polarity and saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_button_debounce;

    localparam int DEB   = 4;
    localparam int MINH  = 6;
    localparam int LONGC = 20;
`ifdef HOLD_STRETCH_EN
    localparam int FALL  = DEB + 2 + MINH;
`else
    localparam int FALL  = DEB + 2;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic raw   = 1'b0;
    logic raw_n = 1'b1;
    logic raw_s = 1'b0;

    logic        lvl, prs, rel, lng;
    logic [15:0] hold;
    logic        n_lvl, n_prs, n_rel, n_lng;
    logic [15:0] n_hold;
    logic        s_lvl, s_prs, s_rel, s_lng;
    logic [3:0]  s_hold;

    always #5 clk = ~clk;

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8), .ACTIVE_LOW(0),
                      .MIN_HOLD(MINH), .HOLD_W(16), .LONG_CYCLES(LONGC)) u_dut (
        .clk(clk), .rst(rst), .btn_raw(raw), .btn_level(lvl), .btn_press(prs),
        .btn_release(rel), .long_press(lng), .hold_cnt(hold));

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8), .ACTIVE_LOW(1),
                      .MIN_HOLD(MINH), .HOLD_W(16), .LONG_CYCLES(LONGC)) u_neg (
        .clk(clk), .rst(rst), .btn_raw(raw_n), .btn_level(n_lvl), .btn_press(n_prs),
        .btn_release(n_rel), .long_press(n_lng), .hold_cnt(n_hold));

    button_debounce #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8), .ACTIVE_LOW(0),
                      .MIN_HOLD(MINH), .HOLD_W(4), .LONG_CYCLES(10)) u_sat (
        .clk(clk), .rst(rst), .btn_raw(raw_s), .btn_level(s_lvl), .btn_press(s_prs),
        .btn_release(s_rel), .long_press(s_lng), .hold_cnt(s_hold));

    typedef struct {
        logic r;
        logic w;
        logic e_lvl;
        logic e_prs;
        logic e_rel;
        logic e_lng;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(input logic r, input logic w, input logic l,
                       input logic p, input logic rl, input int n);
        vec_t v;
        v.r = r; v.w = w; v.e_lvl = l; v.e_prs = p; v.e_rel = rl; v.e_lng = 1'b0;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1; raw = 1'b0; raw_n = 1'b1; raw_s = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- vector table ----------------
        add(1, 0, 0, 0, 0, 2);            // reset
        add(0, 0, 0, 0, 0, 2);            // idle
        add(0, 1, 0, 0, 0, 3);            // 3-cycle glitch
        add(0, 0, 0, 0, 0, 5);            // rejected, back to idle
        add(0, 1, 0, 0, 0, 6);            // edges 0..5 still low
        add(0, 1, 1, 1, 0, 1);            // edge 6: accepted, press strobe
        add(0, 1, 1, 0, 0, 3);            // strobe gone
        add(0, 0, 1, 0, 0, 2);            // release glitch
        add(0, 1, 1, 0, 0, 4);            // back to pressed, no release
        for (int i = 0; i <= FALL + 1; i++)
            add(0, 0, (i < FALL), 1'b0, (i == FALL), 1);

        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r;
            raw = tbl[i].w;
            step(1);
            chk($sformatf("vec%0d_level", i),   lvl, tbl[i].e_lvl);
            chk($sformatf("vec%0d_press", i),   prs, tbl[i].e_prs);
            chk($sformatf("vec%0d_release", i), rel, tbl[i].e_rel);
            chk($sformatf("vec%0d_long", i),    lng, tbl[i].e_lng);
        end
        chk("neg_idle_level", n_lvl, 0);

        // ---------------- hold counter / long press ----------------
        do_reset();
        raw = 1'b1;
        step(DEB + 3);
        chk("hold_accept_level", lvl, 1);
        chk("hold_accept_cnt", hold, 0);
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk($sformatf("hold_cnt_%0d", k), hold, k);
            chk($sformatf("long_%0d", k), lng, (k >= LONGC));
        end
        raw = 1'b0;
        step(DEB + 2);                    // edges 0..5: counting continues
        chk("hold_release_wait_cnt", hold, 36);
        chk("hold_release_wait_level", lvl, 1);
        step(1);
`ifdef HOLD_STRETCH_EN
        chk("hold_stretch_frozen", hold, 36);
        chk("hold_stretch_level", lvl, 1);
        step(MINH);
`endif
        chk("hold_after_release_level", lvl, 0);
        chk("hold_after_release_cnt", hold, 0);
        chk("hold_after_release_long", lng, 0);
        chk("hold_after_release_strobe", rel, 1);

`ifdef HOLD_STRETCH_EN
        // ---------------- re-press during stretch is ignored ----------------
        do_reset();
        raw = 1'b1;
        step(DEB + 3 + 3);
        raw = 1'b0;
        step(DEB + 3);                    // edges 0..6: now stretching
        raw = 1'b1;
        step(MINH - 1);                   // edges 7..11
        chk("stretch_repress_level", lvl, 1);
        chk("stretch_repress_no_rel", rel, 0);
        chk("stretch_hold_frozen", hold, 9);
        step(1);                          // edge 12
        chk("stretch_end_level", lvl, 0);
        chk("stretch_end_release", rel, 1);
`endif

        // ---------------- reset mid PRESS_WAIT ----------------
        do_reset();
        raw = 1'b1;
        step(4);
        rst = 1'b1; raw = 1'b0;
        step(1);
        chk("rst_pw_level", lvl, 0);
        chk("rst_pw_press", prs, 0);
        chk("rst_pw_hold", hold, 0);
        rst = 1'b0;
        step(DEB + 4);
        chk("rst_pw_no_later_press", lvl, 0);

        // ---------------- reset mid PRESSED ----------------
        raw = 1'b1;
        step(DEB + 3 + LONGC + 2);
        chk("pre_rst_long", lng, 1);
        rst = 1'b1; raw = 1'b0;
        step(1);
        chk("rst_pr_level", lvl, 0);
        chk("rst_pr_long", lng, 0);
        chk("rst_pr_hold", hold, 0);
        chk("rst_pr_release", rel, 0);
        rst = 1'b0;

        // ---------------- active-low polarity ----------------
        do_reset();
        step(12);
        chk("neg_no_press_level", n_lvl, 0);
        chk("neg_no_press_strobe", n_prs, 0);
        raw_n = 1'b0;
        step(DEB + 2);
        chk("neg_before_accept", n_lvl, 0);
        step(1);
        chk("neg_accept_level", n_lvl, 1);
        chk("neg_accept_press", n_prs, 1);

        // ---------------- hold counter saturation ----------------
        do_reset();
        raw_s = 1'b1;
        step(DEB + 3);
        chk("sat_accept_level", s_lvl, 1);
        step(14);
        chk("sat_cnt_14", s_hold, 14);
        chk("sat_long_14", s_lng, 1);
        step(5);
        chk("sat_cnt_max", s_hold, 15);
        chk("sat_long_max", s_lng, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
